serial_adder_ctrl: RTL

Bit-serial adder controller that computes WIDTH-bit sums with one 1-bit full-adder slice, one bit per clock, LSB first. Accepts operands with a start/done handshake, keeps the carry in a flop between bit steps, and shifts result bits into a sum register. It sits above the 1-bit full-adder datapath so wide additions share a single slice instead of a ripple chain.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/full_adder_bit.sv | 16 +
 rtl/serial_adder_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, default width and
// the helper that sizes the bit counter.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ceil(log2(w)), never below 1 so the counter always has at least one bit
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder slice shared by every bit step of the serial adder.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic res,
    output logic cout
);

    logic half_sum;

    assign half_sum = x ^ y;
    assign res      = half_sum ^ cin;
    assign cout     = (x & y) | (cin & half_sum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_res;
    logic fa_cout;

    full_adder_bit u_slice (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (carry_q),
        .res  (fa_res),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            // DONE accepts a new request exactly like IDLE for back-to-back adds
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                acc_d   = {fa_res, acc_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    // visible result changes only here; carry_q is the carry into the MSB
                    sum_d   = {fa_res, acc_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
